// File: rtl/mant_mul_seq.sv
// Radix-2 shift-add multiplier for unsigned FP mantissas (hidden bit included).
// Produces the exact 2*WIDTH-bit product over WIDTH RUN cycles with a start/ready/valid handshake.
module mant_mul_seq #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_start,
  input  logic [WIDTH-1:0]     in_multiplicand,
  input  logic [WIDTH-1:0]     in_multiplier,
  output logic                 out_ready,
  output logic                 out_busy,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 out_norm
);

  localparam int PW = 2*WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg;
  logic [PW-1:0]    p_reg;
  logic [PW-1:0]    p_step;
  logic             accept;
  logic             last_step;

  // P is {carry, hi, lo}; the carry is always 0 on entry to a step, so folding
  // it into the upper addend is the same as zero-extending hi.
  function automatic logic [PW-1:0] shift_add_step(input logic [PW-1:0]    p,
                                                   input logic [WIDTH-1:0] a);
    logic [WIDTH:0] sum;
    sum = p[PW-1:WIDTH] + (p[0] ? {1'b0, a} : '0);
    return {sum, p[WIDTH-1:0]} >> 1;
  endfunction

  assign accept    = in_start && (state != RUN);
  assign last_step = (state == RUN) && (cnt == LAST);
  assign p_step    = shift_add_step(p_reg, a_reg);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    out_ready  = 1'b1;
    out_busy   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (in_start) state_next = RUN;
      end
      RUN: begin
        out_ready = 1'b0;
        out_busy  = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid  = 1'b1;
        state_next = in_start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch on accept, one shift-add step per RUN cycle, result capture on the last step.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      cnt         <= '0;
      a_reg       <= '0;
      p_reg       <= '0;
      out_product <= '0;
      out_norm    <= 1'b0;
    end else begin
      if (accept) begin
        a_reg <= in_multiplicand;
        p_reg <= {1'b0, {WIDTH{1'b0}}, in_multiplier};
        cnt   <= '0;
      end else if (state == RUN) begin
        p_reg <= p_step;
        cnt   <= cnt + 1'b1;
      end
      if (last_step) begin
        out_product <= p_step[2*WIDTH-1:0];
        out_norm    <= p_step[2*WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_mant_mul_seq.sv
// Scoreboard bench for mant_mul_seq: expected products queued at launch, popped at out_valid.
module tb_mant_mul_seq;

  logic        in_clk = 1'b0;
  logic        in_rst_n;
  logic        in_start;
  logic [23:0] in_multiplicand;
  logic [23:0] in_multiplier;
  logic        out_ready;
  logic        out_busy;
  logic        out_valid;
  logic [47:0] out_product;
  logic        out_norm;

  logic [47:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          valid_seen = 0;

  always #5 in_clk = ~in_clk;

  mant_mul_seq #(.WIDTH(24), .CNT_W(5)) dut (
    .in_clk          (in_clk),
    .in_rst_n        (in_rst_n),
    .in_start        (in_start),
    .in_multiplicand (in_multiplicand),
    .in_multiplier   (in_multiplier),
    .out_ready       (out_ready),
    .out_busy        (out_busy),
    .out_valid       (out_valid),
    .out_product     (out_product),
    .out_norm        (out_norm)
  );

  always @(negedge in_clk) if (out_valid === 1'b1) valid_seen++;

  // Drive one accepted start; caller must be at a point where out_ready is high.
  task automatic apply_start(input logic [23:0] a, input logic [23:0] b, input logic [47:0] expv);
    in_multiplicand = a;
    in_multiplier   = b;
    in_start        = 1'b1;
    exp_q.push_back(expv);
    @(posedge in_clk); #1;
    in_start        = 1'b0;
    in_multiplicand = 24'($urandom);
    in_multiplier   = 24'($urandom);
  endtask

  // Count edges from the accept edge until out_valid, observing busy/ready/product hold.
  task automatic run_to_valid(input int pulse_at, output int cycles, output int busy_cnt,
                              output int ready_bad, output logic hold_ok);
    logic [47:0] held;
    held      = out_product;
    cycles    = 0;
    busy_cnt  = 0;
    ready_bad = 0;
    hold_ok   = 1'b1;
    if (out_busy === 1'b1) busy_cnt++;
    if (out_ready !== 1'b0) ready_bad++;
    while (cycles < 60) begin
      if (pulse_at != 0 && cycles == pulse_at) begin
        in_start        = 1'b1;
        in_multiplicand = 24'h5A5A5A;
        in_multiplier   = 24'h3C3C3C;
      end
      @(posedge in_clk); #1;
      in_start = 1'b0;
      cycles++;
      if (out_valid === 1'b1) break;
      if (out_busy === 1'b1) busy_cnt++;
      if (out_ready !== 1'b0) ready_bad++;
      if (out_product !== held) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    in_rst_n = 1'b0;
    in_start = 1'b0;
    in_multiplicand = '0;
    in_multiplier   = '0;
    repeat (3) @(posedge in_clk);
    #1;
    checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b need 1", out_ready); end
    checks++; if (out_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b need 0", out_busy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b need 0", out_valid); end
    checks++; if (out_product !== 48'h0) begin failures++; $display("FAIL reset_product: got %h need 0", out_product); end
    checks++; if (out_norm !== 1'b0) begin failures++; $display("FAIL reset_norm: got %b need 0", out_norm); end
    @(negedge in_clk) in_rst_n = 1'b1;
    @(posedge in_clk); #1;
    checks++; if (out_ready !== 1'b1 || out_busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset: ready=%b busy=%b need 1/0", out_ready, out_busy); end
  endtask

  task automatic test_min_norm;
    int cyc, bsy, rbad; logic hold; logic [47:0] e;
    apply_start(24'h800000, 24'h800000, 48'h400000000000);
    run_to_valid(0, cyc, bsy, rbad, hold);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (cyc !== 24) begin failures++; $display("FAIL min_latency: got %0d edges need 24", cyc); end
    checks++; if (out_product !== e) begin failures++; $display("FAIL min_product: got %h need %h", out_product, e); end
    checks++; if (out_norm !== 1'b0) begin failures++; $display("FAIL min_norm: got %b need 0", out_norm); end
    checks++; if (hold !== 1'b1) begin failures++; $display("FAIL min_hold: product changed before valid"); end
  endtask

  task automatic test_max;
    int cyc, bsy, rbad; logic hold; logic [47:0] e;
    @(posedge in_clk); #1;
    apply_start(24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001);
    run_to_valid(0, cyc, bsy, rbad, hold);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (cyc !== 24) begin failures++; $display("FAIL max_latency: got %0d edges need 24", cyc); end
    checks++; if (out_product !== e) begin failures++; $display("FAIL max_product: got %h need %h", out_product, e); end
    checks++; if (out_norm !== 1'b1) begin failures++; $display("FAIL max_norm: got %b need 1", out_norm); end
    @(posedge in_clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL max_valid_pulse: got %b need 0", out_valid); end
    checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL max_idle_ready: got %b need 1", out_ready); end
    checks++; if (out_product !== e) begin failures++; $display("FAIL max_product_hold: got %h need %h", out_product, e); end
  endtask

  task automatic test_busy_ready;
    int cyc, bsy, rbad; logic hold; logic [47:0] e;
    @(posedge in_clk); #1;
    apply_start(24'hC00000, 24'hA00000, 48'h780000000000);
    run_to_valid(0, cyc, bsy, rbad, hold);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (bsy !== 24) begin failures++; $display("FAIL busy_cycles: got %0d need 24", bsy); end
    checks++; if (rbad !== 0) begin failures++; $display("FAIL ready_in_run: got %0d high cycles need 0", rbad); end
    checks++; if (out_product !== e) begin failures++; $display("FAIL busy_product: got %h need %h", out_product, e); end
    checks++; if (out_norm !== 1'b0) begin failures++; $display("FAIL busy_norm: got %b need 0", out_norm); end
  endtask

  task automatic test_zero_ignore;
    int cyc, bsy, rbad, v0; logic hold; logic [47:0] e;
    @(posedge in_clk); #1;
    v0 = valid_seen;
    apply_start(24'h000000, 24'hABCDEF, 48'h0);
    run_to_valid(5, cyc, bsy, rbad, hold);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (cyc !== 24) begin failures++; $display("FAIL zero_latency: got %0d edges need 24", cyc); end
    checks++; if (out_product !== e) begin failures++; $display("FAIL zero_product: got %h need %h", out_product, e); end
    repeat (40) @(posedge in_clk);
    #1;
    checks++; if (valid_seen - v0 !== 1) begin failures++; $display("FAIL zero_single_valid: got %0d pulses need 1", valid_seen - v0); end
    checks++; if (out_busy !== 1'b0) begin failures++; $display("FAIL zero_run_ignored_start: busy=%b need 0", out_busy); end
  endtask

  task automatic test_back_to_back;
    int cyc, bsy, rbad; logic hold; logic [47:0] e;
    @(posedge in_clk); #1;
    apply_start(24'h800000, 24'hC00000, 48'h600000000000);
    run_to_valid(0, cyc, bsy, rbad, hold);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (out_product !== e) begin failures++; $display("FAIL b2b_first_product: got %h need %h", out_product, e); end
    checks++; if (out_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_in_done: got %b need 1", out_ready); end
    apply_start(24'h900000, 24'h900000, 48'h510000000000);
    run_to_valid(0, cyc, bsy, rbad, hold);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (cyc + 1 !== 25) begin failures++; $display("FAIL b2b_spacing: got %0d cycles need 25", cyc + 1); end
    checks++; if (hold !== 1'b1) begin failures++; $display("FAIL b2b_first_hold: first result not held during second run"); end
    checks++; if (out_product !== e) begin failures++; $display("FAIL b2b_second_product: got %h need %h", out_product, e); end
  endtask

  task automatic test_mid_reset;
    int cyc, bsy, rbad, v0; logic hold; logic [47:0] e;
    @(posedge in_clk); #1;
    v0 = valid_seen;
    apply_start(24'hFFFFFF, 24'h800000, 48'h7FFFFF800000);
    repeat (10) @(posedge in_clk);
    #1;
    in_rst_n = 1'b0;
    #1;
    checks++; if (out_product !== 48'h0) begin failures++; $display("FAIL midrst_product: got %h need 0", out_product); end
    checks++; if (out_ready !== 1'b1 || out_busy !== 1'b0 || out_valid !== 1'b0 || out_norm !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl: ready=%b busy=%b valid=%b norm=%b need 1/0/0/0", out_ready, out_busy, out_valid, out_norm);
    end
    exp_q.delete();
    @(posedge in_clk);
    @(negedge in_clk) in_rst_n = 1'b1;
    repeat (40) @(posedge in_clk);
    #1;
    checks++; if (valid_seen - v0 !== 0) begin failures++; $display("FAIL midrst_no_valid: got %0d pulses need 0", valid_seen - v0); end
    apply_start(24'h9ABCDE, 24'hF0F0F1, {24'h0, 24'h9ABCDE} * {24'h0, 24'hF0F0F1});
    run_to_valid(0, cyc, bsy, rbad, hold);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (cyc !== 24) begin failures++; $display("FAIL midrst_next_latency: got %0d edges need 24", cyc); end
    checks++; if (out_product !== e) begin failures++; $display("FAIL midrst_next_product: got %h need %h", out_product, e); end
  endtask

  task automatic test_random;
    int cyc, bsy, rbad; logic hold; logic [47:0] e;
    logic [23:0] a, b;
    for (int i = 0; i < 4; i++) begin
      @(posedge in_clk); #1;
      a = 24'($urandom) | 24'h800000;
      b = 24'($urandom) | 24'h800000;
      apply_start(a, b, {24'h0, a} * {24'h0, b});
      run_to_valid(0, cyc, bsy, rbad, hold);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      checks++; if (out_product !== e) begin failures++; $display("FAIL rand_product[%0d]: a=%h b=%h got %h need %h", i, a, b, out_product, e); end
      checks++; if (out_norm !== e[47]) begin failures++; $display("FAIL rand_norm[%0d]: got %b need %b", i, out_norm, e[47]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_min_norm();
    test_max();
    test_busy_ready();
    test_zero_ignore();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mant_mul_seq.md
Name: mant_mul_seq

Overview:
Iterative radix-2 shift-add multiplier for unsigned floating-point mantissas. It is the multiply-side counterpart of the FP divide mantissa datapath. It takes two WIDTH-bit mantissas with the hidden bit included and produces the full 2*WIDTH-bit product over WIDTH clock cycles. It sits in the FP_Unit multiply path, between operand unpacking and normalization/rounding. It uses a start/ready/valid handshake so the FP control FSM can launch operations and collect results.

Parameters:
WIDTH, 24, mantissa width in bits, hidden bit included; product width is 2*WIDTH.
CNT_W, 5, width of the step counter; must satisfy 2^CNT_W > WIDTH.

Ports:
in_clk  input  1  clock; all state updates on the rising edge.
in_rst_n  input  1  asynchronous active-low reset.
in_start  input  1  launch request; sampled only while out_ready=1.
in_multiplicand  input  WIDTH  mantissa A; sampled on an accepted start.
in_multiplier  input  WIDTH  mantissa B; sampled on an accepted start.
out_ready  output  1  high in IDLE and DONE; block can accept in_start.
out_busy  output  1  high in RUN.
out_valid  output  1  one-cycle pulse; out_product is a new result.
out_product  output  2*WIDTH  A*B, unsigned, exact.
out_norm  output  1  equals out_product[2*WIDTH-1]; tells the normalizer to shift by 1.

Behaviour:
- Reset (in_rst_n=0, asynchronous): state=IDLE, counter=0, all internal registers=0.
- Output values during reset: out_product=0, out_norm=0, out_valid=0, out_busy=0, out_ready=1.
- Internal state: multiplicand register A (WIDTH bits) and a partial-product register P of 2*WIDTH+1 bits, laid out as {carry, hi[WIDTH-1:0], lo[WIDTH-1:0]}.
- IDLE: out_ready=1.
  - Start accepted (in_start=1): A<=in_multiplicand, P<={1'b0, WIDTH'b0, in_multiplier}, counter<=0, next state RUN.
- RUN: out_busy=1, out_ready=0. Each cycle performs one step:
  - sum = {1'b0,hi} + (lo[0] ? {1'b0,A} : 0), WIDTH+1 bits.
  - P <= {sum, lo} >> 1, a logical shift right.
  - counter <= counter+1.
  - When counter==WIDTH-1, the step completes: out_product <= the updated P[2*WIDTH-1:0], next state DONE.
  - in_start is ignored in RUN; no queuing and no error flag.
- DONE: lasts exactly one cycle. out_valid=1, out_ready=1.
  - in_start=1 in DONE: accepted exactly as in IDLE, next state RUN. This allows back-to-back operation with one idle-free handshake cycle.
  - Otherwise next state is IDLE.
- Latency: start accepted at rising edge k; out_valid is high during the cycle following edge k+WIDTH (WIDTH RUN cycles). Throughput is one result per WIDTH+1 cycles.
- out_product and out_norm are registered. They hold their value from DONE until the next DONE; a new start does not clear them.
- out_norm is registered together with out_product from the same bit.
- Width rules: no overflow is possible; the final carry bit is always 0 after the last shift.
- Operand of zero: still takes the full WIDTH cycles; result is 0.
- Mid-operation reset: aborts immediately to the reset values; no out_valid pulse is produced.
- Operands may change freely after the accept edge; only the latched copies are used.

Test Plan:
- Reset, then start with A=0x800000, B=0x800000 -> out_valid exactly 24 cycles after the accept edge, out_product=0x400000000000, out_norm=0.
- A=0xFFFFFF, B=0xFFFFFF -> out_product=0xFFFFFE000001, out_norm=1, out_valid high for exactly one cycle.
- A=0xC00000, B=0xA00000 -> out_product=0x780000000000, out_norm=0; out_busy high for 24 cycles; out_ready low throughout RUN.
- A=0x000000, B=0xABCDEF -> out_product=0 after 24 cycles. Pulse in_start with other operands during RUN -> ignored; exactly one out_valid.
- Back-to-back: hold in_start=1 in DONE with A=0x900000, B=0x900000 -> second result 0x510000000000 exactly 25 cycles after the first out_valid. First result holds until then.
- Assert in_rst_n=0 for 1 cycle at RUN step 10 -> all outputs at reset values immediately. No out_valid afterwards. Next start completes normally.
